// File: rtl/fpu_pp_pkg.sv
// Shared types and helpers for the FPU post-processing arbiter.
// Round-robin helpers are only referenced when FPU_PP_ROUNDROBIN_EN is defined.
package fpu_pp_pkg;

  typedef enum logic [1:0] {PP_NONE, PP_FMA, PP_DIV, PP_CVT} pp_src_t;

  localparam int unsigned PP_NSRC  = 3;
  localparam int unsigned PP_CNT_W = 4;

  // Request vectors are ordered {Cvt, Div, Fma}.
  function automatic logic pp_req_of(input pp_src_t s, input logic [PP_NSRC-1:0] req);
    case (s)
      PP_FMA:  return req[0];
      PP_DIV:  return req[1];
      PP_CVT:  return req[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic pp_src_t pp_rr_next(input pp_src_t s);
    case (s)
      PP_FMA:  return PP_DIV;
      PP_DIV:  return PP_CVT;
      default: return PP_FMA;
    endcase
  endfunction

  // First requester found scanning Fma->Div->Cvt, starting at ptr.
  function automatic pp_src_t pp_rr_pick(input pp_src_t ptr, input logic [PP_NSRC-1:0] req);
    pp_src_t s;
    pp_src_t pick;
    s    = (ptr == PP_NONE) ? PP_FMA : ptr;
    pick = PP_NONE;
    for (int k = 0; k < PP_NSRC; k++) begin
      if (pick == PP_NONE && pp_req_of(s, req)) pick = s;
      s = pp_rr_next(s);
    end
    return pick;
  endfunction

endpackage

// File: rtl/fpu_pp_starvectr.sv
// Saturating per-requester wait counter; promote flags a requester that has
// waited STARVE_MAX cycles and is still requesting.
module fpu_pp_starvectr
  import fpu_pp_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic                i_gnt,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic [PP_CNT_W-1:0] o_count,
  output logic                o_promote
);

  localparam logic [PP_CNT_W-1:0] LP_MAX = PP_CNT_W'(STARVE_MAX);

  logic [PP_CNT_W-1:0] r_count;
  logic [PP_CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_flush || !i_req || (i_gnt && !i_stall)) begin
      w_count_d = '0;
    end else if (r_count != LP_MAX) begin
      w_count_d = r_count + PP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_count   = r_count;
  assign o_promote = i_req && (r_count == LP_MAX);

endmodule

// File: rtl/fpu_postproc_arb.sv
// Arbiter + issue register sharing the FPU post-processor among FMA, divsqrt, convert.
// Define FPU_PP_ROUNDROBIN_EN for round-robin base policy; default is fixed Div>Fma>Cvt.
module fpu_postproc_arb
  import fpu_pp_pkg::*;
#(
  parameter int unsigned TAGW       = 5,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            FmaReq,
  input  logic            FmaSs,
  input  logic [TAGW-1:0] FmaTag,
  output logic            FmaGnt,
  input  logic            DivReq,
  input  logic            DivXs,
  input  logic            DivYs,
  input  logic            DivSqrt,
  input  logic [TAGW-1:0] DivTag,
  output logic            DivGnt,
  input  logic            CvtReq,
  input  logic            CvtCs,
  input  logic [TAGW-1:0] CvtTag,
  output logic            CvtGnt,
  input  logic            PpReady,
  output logic            PpValid,
  output logic            FmaOp,
  output logic            DivOp,
  output logic            CvtOp,
  output logic            Xs,
  output logic            Ys,
  output logic            Sqrt,
  output logic            FmaSs_q,
  output logic            CvtCs_q,
  output logic [TAGW-1:0] Tag
);

  // Vectors ordered {Cvt, Div, Fma}.
  logic [PP_NSRC-1:0]  w_req;
  logic [PP_NSRC-1:0]  w_prom;
  logic [PP_NSRC-1:0]  w_gnt;
  logic [PP_CNT_W-1:0] w_fma_cnt, w_div_cnt, w_cvt_cnt;
  logic                w_accept, w_stall, w_can_gnt, w_promoted;
  pp_src_t             w_sel;

  logic                r_valid;
  pp_src_t             r_src;
  logic                r_xs, r_ys, r_sqrt, r_fss, r_ccs;
  logic [TAGW-1:0]     r_tag;
  logic [TAGW-1:0]     w_ld_tag;

  assign w_req     = {CvtReq, DivReq, FmaReq};
  assign w_accept  = ~r_valid | PpReady;
  assign w_stall   = r_valid & ~PpReady;
  assign w_can_gnt = w_accept & ~FlushE & ~reset;

  fpu_pp_starvectr #(.STARVE_MAX(STARVE_MAX)) u_fma_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (FmaReq),
    .i_gnt    (w_gnt[0]),
    .i_stall  (w_stall),
    .i_flush  (FlushE),
    .o_count  (w_fma_cnt),
    .o_promote(w_prom[0])
  );

  fpu_pp_starvectr #(.STARVE_MAX(STARVE_MAX)) u_div_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (DivReq),
    .i_gnt    (w_gnt[1]),
    .i_stall  (w_stall),
    .i_flush  (FlushE),
    .o_count  (w_div_cnt),
    .o_promote(w_prom[1])
  );

  fpu_pp_starvectr #(.STARVE_MAX(STARVE_MAX)) u_cvt_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (CvtReq),
    .i_gnt    (w_gnt[2]),
    .i_stall  (w_stall),
    .i_flush  (FlushE),
    .o_count  (w_cvt_cnt),
    .o_promote(w_prom[2])
  );

  // Raw counts are kept for debug visibility; arbitration only needs promote.
  logic w_unused_cnt;
  assign w_unused_cnt = ^{w_fma_cnt, w_div_cnt, w_cvt_cnt};

`ifdef FPU_PP_ROUNDROBIN_EN
  pp_src_t r_rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= PP_FMA;
    end else if ((|w_gnt) && !w_promoted) begin
      r_rr_ptr <= pp_rr_next(w_sel);
    end
  end
`endif

  always_comb begin
    w_sel      = PP_NONE;
    w_promoted = 1'b0;
    if (w_prom[1]) begin
      w_sel      = PP_DIV;
      w_promoted = 1'b1;
    end else if (w_prom[0]) begin
      w_sel      = PP_FMA;
      w_promoted = 1'b1;
    end else if (w_prom[2]) begin
      w_sel      = PP_CVT;
      w_promoted = 1'b1;
    end else begin
`ifdef FPU_PP_ROUNDROBIN_EN
      w_sel = pp_rr_pick(r_rr_ptr, w_req);
`else
      if (w_req[1])      w_sel = PP_DIV;
      else if (w_req[0]) w_sel = PP_FMA;
      else if (w_req[2]) w_sel = PP_CVT;
`endif
    end
  end

  assign w_gnt[0] = w_can_gnt & (w_sel == PP_FMA);
  assign w_gnt[1] = w_can_gnt & (w_sel == PP_DIV);
  assign w_gnt[2] = w_can_gnt & (w_sel == PP_CVT);
  assign FmaGnt   = w_gnt[0];
  assign DivGnt   = w_gnt[1];
  assign CvtGnt   = w_gnt[2];

  always_comb begin
    w_ld_tag = '0;
    case (w_sel)
      PP_FMA:  w_ld_tag = FmaTag;
      PP_DIV:  w_ld_tag = DivTag;
      PP_CVT:  w_ld_tag = CvtTag;
      default: w_ld_tag = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_src   <= PP_NONE;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_sqrt  <= 1'b0;
      r_fss   <= 1'b0;
      r_ccs   <= 1'b0;
      r_tag   <= '0;
    end else if (FlushE) begin
      r_valid <= 1'b0;
      r_src   <= PP_NONE;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_sqrt  <= 1'b0;
      r_fss   <= 1'b0;
      r_ccs   <= 1'b0;
      r_tag   <= '0;
    end else if (w_accept) begin
      // With no request w_sel is PP_NONE, which empties the register.
      r_valid <= (w_sel != PP_NONE);
      r_src   <= w_sel;
      r_xs    <= (w_sel == PP_DIV) & DivXs;
      r_ys    <= (w_sel == PP_DIV) & DivYs;
      r_sqrt  <= (w_sel == PP_DIV) & DivSqrt;
      r_fss   <= (w_sel == PP_FMA) & FmaSs;
      r_ccs   <= (w_sel == PP_CVT) & CvtCs;
      r_tag   <= w_ld_tag;
    end
  end

  assign PpValid = r_valid;
  assign FmaOp   = (r_src == PP_FMA);
  assign DivOp   = (r_src == PP_DIV);
  assign CvtOp   = (r_src == PP_CVT);
  assign Xs      = r_xs;
  assign Ys      = r_ys;
  assign Sqrt    = r_sqrt;
  assign FmaSs_q = r_fss;
  assign CvtCs_q = r_ccs;
  assign Tag     = r_tag;

endmodule
